alu_op_sequencer: RTL and testbench



---
 rtl/alu_seq_pkg.sv | 111 +++++++++++
 rtl/reg_sel_decoder.sv | 20 ++
 rtl/alu_op_sequencer.sv | 264 ++++++++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU control-step sequencer.
// Holds the 5-bit opcode values, ALUControl bit positions, the state encoding,
// the instruction-class encoding, the strobe bundle type and helpers that
// locate the IR fields and map an opcode to its one-hot ALU select.
package alu_seq_pkg;

  localparam int unsigned OpcW = 5;
  localparam int unsigned AluW = 12;

  localparam logic [OpcW-1:0] OpcAdd  = 5'b00011;
  localparam logic [OpcW-1:0] OpcSub  = 5'b00100;
  localparam logic [OpcW-1:0] OpcAnd  = 5'b00101;
  localparam logic [OpcW-1:0] OpcOr   = 5'b00110;
  localparam logic [OpcW-1:0] OpcShr  = 5'b00111;
  localparam logic [OpcW-1:0] OpcShra = 5'b01000;
  localparam logic [OpcW-1:0] OpcShl  = 5'b01001;
  localparam logic [OpcW-1:0] OpcRor  = 5'b01010;
  localparam logic [OpcW-1:0] OpcRol  = 5'b01011;
  localparam logic [OpcW-1:0] OpcMul  = 5'b01111;
  localparam logic [OpcW-1:0] OpcDiv  = 5'b10000;
  localparam logic [OpcW-1:0] OpcNeg  = 5'b10001;

  localparam int unsigned AluAdd  = 0;
  localparam int unsigned AluSub  = 1;
  localparam int unsigned AluAnd  = 2;
  localparam int unsigned AluOr   = 3;
  localparam int unsigned AluShr  = 4;
  localparam int unsigned AluShra = 5;
  localparam int unsigned AluShl  = 6;
  localparam int unsigned AluRor  = 7;
  localparam int unsigned AluRol  = 8;
  localparam int unsigned AluMul  = 9;
  localparam int unsigned AluDiv  = 10;
  localparam int unsigned AluNeg  = 11;

  typedef enum logic [3:0] {
    StIdle, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StIll
  } state_e;

  typedef enum logic [1:0] {
    OpThree, OpNeg, OpMulDiv
  } op_class_e;

  // Single-bit datapath strobes plus the ALU select, registered as one bundle.
  typedef struct packed {
    logic            busy;
    logic            done;
    logic            illegal;
    logic            pc_out;
    logic            mar_in;
    logic            inc_pc;
    logic            pc_in;
    logic            mdr_read;
    logic            mdr_in;
    logic            mdr_out;
    logic            ir_in;
    logic            y_in;
    logic            z_in;
    logic            zlow_out;
    logic            zhigh_out;
    logic            lo_in;
    logic            hi_in;
    logic [AluW-1:0] alu;
  } ctrl_t;

  // MSB positions of the register fields, packed directly below the opcode.
  function automatic int unsigned ra_msb(input int unsigned word);
    return word - OpcW - 1;
  endfunction

  function automatic int unsigned rb_msb(input int unsigned word, input int unsigned rsel_w);
    return word - OpcW - 1 - rsel_w;
  endfunction

  function automatic int unsigned rc_msb(input int unsigned word, input int unsigned rsel_w);
    return word - OpcW - 1 - 2 * rsel_w;
  endfunction

  // Returns all-zero for an unsupported opcode.
  function automatic logic [AluW-1:0] opc_to_alu(input logic [OpcW-1:0] opc);
    logic [AluW-1:0] a;
    a = '0;
    case (opc)
      OpcAdd:  a[AluAdd]  = 1'b1;
      OpcSub:  a[AluSub]  = 1'b1;
      OpcAnd:  a[AluAnd]  = 1'b1;
      OpcOr:   a[AluOr]   = 1'b1;
      OpcShr:  a[AluShr]  = 1'b1;
      OpcShra: a[AluShra] = 1'b1;
      OpcShl:  a[AluShl]  = 1'b1;
      OpcRor:  a[AluRor]  = 1'b1;
      OpcRol:  a[AluRol]  = 1'b1;
      OpcMul:  a[AluMul]  = 1'b1;
      OpcDiv:  a[AluDiv]  = 1'b1;
      OpcNeg:  a[AluNeg]  = 1'b1;
      default: a = '0;
    endcase
    return a;
  endfunction

  function automatic op_class_e opc_class(input logic [OpcW-1:0] opc);
    op_class_e c;
    case (opc)
      OpcMul, OpcDiv: c = OpMulDiv;
      OpcNeg:         c = OpNeg;
      default:        c = OpThree;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/reg_sel_decoder.sv
// Binary register select to one-hot register strobe.
// Ports: sel_i - register number; en_i - drive any bit at all;
//        onehot_o - NREG-wide one-hot (all zero when en_i is low).
module reg_sel_decoder #(
  parameter int unsigned NREG   = 16,
  parameter int unsigned RSEL_W = $clog2(NREG)
) (
  input  logic [RSEL_W-1:0] sel_i,
  input  logic              en_i,
  output logic [NREG-1:0]   onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o = NREG'(1) << sel_i;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Control-step sequencer for register-to-register ALU instructions on a
// single shared datapath bus. Walks fetch (T0..T2), decodes the opcode and
// then emits the execute steps for three-register, NEG and MUL/DIV forms.
// Ports:
//   clk, clr       clock and synchronous active-high reset
//   start          begin an instruction (honoured in IDLE and the final step)
//   ir             instruction register contents
//   busy/done      sequencer activity and final-step flag
//   illegal        one-cycle pulse for an unsupported opcode
//   Rout/Rin       one-hot register-file bus drive / load
//   PCout..HIin    datapath strobes
//   ALUControl     one-hot ALU operation select
// All outputs are flops loaded from the decode of the next state, so nothing
// on start or ir reaches an output pin combinationally.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned NREG    = 16,
  parameter int unsigned RSEL_W  = $clog2(NREG),
  parameter int unsigned WORD    = 32,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [WORD-1:0]   ir,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic [NREG-1:0]   Rout,
  output logic [NREG-1:0]   Rin,
  output logic              PCout,
  output logic              MARin,
  output logic              IncPC,
  output logic              PCin,
  output logic              MDRRead,
  output logic              MDRin,
  output logic              MDRout,
  output logic              IRin,
  output logic              Yin,
  output logic              Zin,
  output logic              Zlowout,
  output logic              Zhighout,
  output logic              LOin,
  output logic              HIin,
  output logic [AluW-1:0]   ALUControl
);

  localparam int unsigned CntW = $clog2(ALU_LAT + 1);
  localparam int unsigned RaMsb = ra_msb(WORD);
  localparam int unsigned RbMsb = rb_msb(WORD, RSEL_W);
  localparam int unsigned RcMsb = rc_msb(WORD, RSEL_W);

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  op_class_e          op_q, op_d;
  logic [AluW-1:0]    alu_q, alu_d;
  logic [RSEL_W-1:0]  ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;

  ctrl_t              ctrl_q, ctrl_d;
  logic [NREG-1:0]    rout_q, rout_d, rin_q, rin_d;
  logic [RSEL_W-1:0]  rout_sel_d, rin_sel_d;
  logic               rout_en_d, rin_en_d;

  logic [OpcW-1:0]    opc;
  logic [AluW-1:0]    dec_alu;
  logic               unused_ir;

  assign opc       = ir[WORD-1 -: OpcW];
  assign dec_alu   = opc_to_alu(opc);
  assign unused_ir = ^ir;

  // Next-state logic; instruction fields are captured once at the end of T2.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    alu_d   = alu_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rc_d    = rc_q;
    unique case (state_q)
      StIdle: if (start) state_d = StT0;
      StT0:   state_d = StT1;
      StT1:   state_d = StT2;
      StT2: begin
        if (dec_alu == '0) begin
          state_d = StIll;
        end else begin
          state_d = StT3;
          alu_d   = dec_alu;
          op_d    = opc_class(opc);
          ra_d    = ir[RaMsb -: RSEL_W];
          rb_d    = ir[RbMsb -: RSEL_W];
          rc_d    = ir[RcMsb -: RSEL_W];
        end
      end
      StT3: begin
        unique case (op_q)
          OpNeg:    state_d = StT5;
          OpMulDiv: begin
            state_d = StT4;
            cnt_d   = CntW'(ALU_LAT);
          end
          default: begin
            state_d = StT4;
            cnt_d   = CntW'(1);
          end
        endcase
      end
      StT4: begin
        if (cnt_q == CntW'(1)) begin
          state_d = StT5;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StT5: begin
        if (op_q == OpMulDiv) state_d = StT6;
        else                  state_d = start ? StT0 : StIdle;
      end
      StT6:   state_d = start ? StT0 : StIdle;
      StIll:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode of the upcoming state; the result is registered below.
  always_comb begin
    ctrl_d     = '0;
    rout_en_d  = 1'b0;
    rin_en_d   = 1'b0;
    rout_sel_d = rb_d;
    rin_sel_d  = ra_d;
    ctrl_d.busy = (state_d != StIdle);
    unique case (state_d)
      StIdle: ;
      StT0: begin
        ctrl_d.pc_out = 1'b1;
        ctrl_d.mar_in = 1'b1;
        ctrl_d.inc_pc = 1'b1;
        ctrl_d.z_in   = 1'b1;
      end
      StT1: begin
        ctrl_d.zlow_out = 1'b1;
        ctrl_d.pc_in    = 1'b1;
        ctrl_d.mdr_read = 1'b1;
        ctrl_d.mdr_in   = 1'b1;
      end
      StT2: begin
        ctrl_d.mdr_out = 1'b1;
        ctrl_d.ir_in   = 1'b1;
      end
      StT3: begin
        rout_en_d = 1'b1;
        unique case (op_d)
          OpMulDiv: begin
            rout_sel_d  = ra_d;
            ctrl_d.y_in = 1'b1;
          end
          OpNeg: begin
            ctrl_d.alu  = alu_d;
            ctrl_d.z_in = 1'b1;
          end
          default: ctrl_d.y_in = 1'b1;
        endcase
      end
      StT4: begin
        rout_en_d  = 1'b1;
        ctrl_d.alu = alu_d;
        if (op_d == OpMulDiv) begin
          // Z captures the product/quotient only once the ALU has settled.
          ctrl_d.z_in = (cnt_d == CntW'(1));
        end else begin
          rout_sel_d  = rc_d;
          ctrl_d.z_in = 1'b1;
        end
      end
      StT5: begin
        ctrl_d.zlow_out = 1'b1;
        if (op_d == OpMulDiv) begin
          ctrl_d.lo_in = 1'b1;
        end else begin
          rin_en_d    = 1'b1;
          ctrl_d.done = 1'b1;
        end
      end
      StT6: begin
        ctrl_d.zhigh_out = 1'b1;
        ctrl_d.hi_in     = 1'b1;
        ctrl_d.done      = 1'b1;
      end
      StIll:  ctrl_d.illegal = 1'b1;
      default: ;
    endcase
  end

  reg_sel_decoder #(
    .NREG   (NREG),
    .RSEL_W (RSEL_W)
  ) u_rout_dec (
    .sel_i    (rout_sel_d),
    .en_i     (rout_en_d),
    .onehot_o (rout_d)
  );

  reg_sel_decoder #(
    .NREG   (NREG),
    .RSEL_W (RSEL_W)
  ) u_rin_dec (
    .sel_i    (rin_sel_d),
    .en_i     (rin_en_d),
    .onehot_o (rin_d)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= OpThree;
      alu_q   <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rc_q    <= '0;
      ctrl_q  <= '0;
      rout_q  <= '0;
      rin_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      alu_q   <= alu_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rc_q    <= rc_d;
      ctrl_q  <= ctrl_d;
      rout_q  <= rout_d;
      rin_q   <= rin_d;
    end
  end

  assign busy       = ctrl_q.busy;
  assign done       = ctrl_q.done;
  assign illegal    = ctrl_q.illegal;
  assign Rout       = rout_q;
  assign Rin        = rin_q;
  assign PCout      = ctrl_q.pc_out;
  assign MARin      = ctrl_q.mar_in;
  assign IncPC      = ctrl_q.inc_pc;
  assign PCin       = ctrl_q.pc_in;
  assign MDRRead    = ctrl_q.mdr_read;
  assign MDRin      = ctrl_q.mdr_in;
  assign MDRout     = ctrl_q.mdr_out;
  assign IRin       = ctrl_q.ir_in;
  assign Yin        = ctrl_q.y_in;
  assign Zin        = ctrl_q.z_in;
  assign Zlowout    = ctrl_q.zlow_out;
  assign Zhighout   = ctrl_q.zhigh_out;
  assign LOin       = ctrl_q.lo_in;
  assign HIin       = ctrl_q.hi_in;
  assign ALUControl = ctrl_q.alu;

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [31:0] ir;
  logic        busy, done, illegal;
  logic [15:0] Rout, Rin;
  logic        PCout, MARin, IncPC, PCin, MDRRead, MDRin, MDRout, IRin;
  logic        Yin, Zin, Zlowout, Zhighout, LOin, HIin;
  logic [11:0] ALUControl;
  logic [63:0] all_out;

  int checks   = 0;
  int failures = 0;

  alu_op_sequencer #(
    .NREG    (16),
    .WORD    (32),
    .ALU_LAT (4)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .start      (start),
    .ir         (ir),
    .busy       (busy),
    .done       (done),
    .illegal    (illegal),
    .Rout       (Rout),
    .Rin        (Rin),
    .PCout      (PCout),
    .MARin      (MARin),
    .IncPC      (IncPC),
    .PCin       (PCin),
    .MDRRead    (MDRRead),
    .MDRin      (MDRin),
    .MDRout     (MDRout),
    .IRin       (IRin),
    .Yin        (Yin),
    .Zin        (Zin),
    .Zlowout    (Zlowout),
    .Zhighout   (Zhighout),
    .LOin       (LOin),
    .HIin       (HIin),
    .ALUControl (ALUControl)
  );

  always #5 clk = ~clk;

  assign all_out = {3'b0, busy, done, illegal, Rout, Rin, PCout, MARin, IncPC, PCin, MDRRead,
                    MDRin, MDRout, IRin, Yin, Zin, Zlowout, Zhighout, LOin, HIin, ALUControl};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_ir(input logic [4:0] opc, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rc);
    return {opc, ra, rb, rc, 15'b0};
  endfunction

  // Per-cycle structural rules: one bus driver, one-hot register strobes.
  task automatic chk_invariants(input string nm);
    int drivers;
    drivers = int'(PCout) + int'(MDRout) + int'(Zlowout) + int'(Zhighout) + int'(|Rout);
    chk({nm, " bus_drivers<=1"}, 64'(drivers <= 1), 64'(1));
    chk({nm, " rout_rin_onehot0"},
        64'($onehot0(Rout) && $onehot0(Rin) && !((|Rout) && (|Rin))), 64'(1));
  endtask

  typedef struct {
    string       name;
    logic [31:0] ir;
    logic [11:0] alu;
    int          cycles;
    int          done_at;
    int          ill_at;
    logic [15:0] rout3;
    logic [15:0] rout4;
    logic [15:0] rin;
    int          zin_cnt;
    bit          lohi;
  } vec_t;

  vec_t vecs[9];

  initial begin
    clr   = 1'b1;
    start = 1'b1;
    ir    = 32'h22920000;

    vecs[0] = '{"sub",  32'h22920000,           12'h002, 6, 5, -1, 16'h0004, 16'h0010,
                16'h0020, 2, 1'b0};
    vecs[1] = '{"add",  mk_ir(5'b00011, 1, 2, 3),  12'h001, 6, 5, -1, 16'h0004, 16'h0008,
                16'h0002, 2, 1'b0};
    vecs[2] = '{"rol",  mk_ir(5'b01011, 15, 0, 14), 12'h100, 6, 5, -1, 16'h0001, 16'h4000,
                16'h8000, 2, 1'b0};
    vecs[3] = '{"shra", mk_ir(5'b01000, 4, 4, 4),  12'h020, 6, 5, -1, 16'h0010, 16'h0010,
                16'h0010, 2, 1'b0};
    vecs[4] = '{"neg",  mk_ir(5'b10001, 9, 6, 0),  12'h800, 5, 4, -1, 16'h0040, 16'h0000,
                16'h0200, 2, 1'b0};
    vecs[5] = '{"mul",  32'h79B80000,           12'h200, 10, 9, -1, 16'h0008, 16'h0080,
                16'h0000, 2, 1'b1};
    vecs[6] = '{"div",  mk_ir(5'b10000, 0, 12, 0), 12'h400, 10, 9, -1, 16'h0001, 16'h1000,
                16'h0000, 2, 1'b1};
    vecs[7] = '{"ill1f", 32'hF8000000,          12'h000, 4, -1, 3, 16'h0000, 16'h0000,
                16'h0000, 1, 1'b0};
    vecs[8] = '{"ill00", 32'h00000000,          12'h000, 4, -1, 3, 16'h0000, 16'h0000,
                16'h0000, 1, 1'b0};

    // Reset held two cycles with start asserted: everything stays quiet.
    @(negedge clk);
    chk("reset cyc1 outputs", all_out, 64'h0);
    @(negedge clk);
    chk("reset cyc2 outputs", all_out, 64'h0);
    clr = 1'b0;
    @(negedge clk);
    chk("post-reset T0 busy", 64'(busy), 64'(1));
    chk("post-reset T0 PCout", 64'(PCout), 64'(1));
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    chk("post-reset run reaches idle", 64'(busy), 64'(0));

    // Table-driven single instructions.
    for (int v = 0; v < 9; v++) begin
      int          done_at, ill_at, busy_cnt, zin_cnt;
      logic [11:0] alu_or;
      logic [15:0] rin_or, r3, r4;
      bit          lohi;
      done_at = -1; ill_at = -1; busy_cnt = 0; zin_cnt = 0;
      alu_or = '0; rin_or = '0; r3 = '0; r4 = '0; lohi = 1'b0;
      @(negedge clk);
      ir    = vecs[v].ir;
      start = 1'b1;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        start = 1'b0;
        if (!busy) break;
        busy_cnt++;
        if (done && done_at < 0) done_at = c;
        if (illegal) ill_at = c;
        if (Zin) zin_cnt++;
        alu_or |= ALUControl;
        rin_or |= Rin;
        if (c == 3) r3 = Rout;
        if (c == 4) r4 = Rout;
        if (LOin || HIin) lohi = 1'b1;
        chk_invariants($sformatf("%s c%0d", vecs[v].name, c));
      end
      chk({vecs[v].name, " busy_cycles"}, 64'(busy_cnt), 64'(vecs[v].cycles));
      chk({vecs[v].name, " done_at"},     64'(done_at),  64'(vecs[v].done_at));
      chk({vecs[v].name, " illegal_at"},  64'(ill_at),   64'(vecs[v].ill_at));
      chk({vecs[v].name, " alu_sel"},     64'(alu_or),   64'(vecs[v].alu));
      chk({vecs[v].name, " rout_t3"},     64'(r3),       64'(vecs[v].rout3));
      chk({vecs[v].name, " rout_c4"},     64'(r4),       64'(vecs[v].rout4));
      chk({vecs[v].name, " rin"},         64'(rin_or),   64'(vecs[v].rin));
      chk({vecs[v].name, " zin_count"},   64'(zin_cnt),  64'(vecs[v].zin_cnt));
      chk({vecs[v].name, " lo_hi"},       64'(lohi),     64'(vecs[v].lohi));
    end

    // MUL: Zin only in the last of the four T4 cycles.
    begin
      logic [9:0] zin_v;
      zin_v = '0;
      @(negedge clk);
      ir    = 32'h79B80000;
      start = 1'b1;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        start    = 1'b0;
        zin_v[c] = Zin;
      end
      chk("mul zin cycle map", 64'(zin_v), 64'(10'b00_1000_0001));
      @(negedge clk);
      chk("mul idle after", 64'(busy), 64'(0));
    end

    // Back-to-back SUBs with start held high.
    begin
      logic [11:0] busy_v, done_v, pc_v;
      busy_v = '0; done_v = '0; pc_v = '0;
      @(negedge clk);
      ir    = 32'h22920000;
      start = 1'b1;
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        busy_v[c] = busy;
        done_v[c] = done;
        pc_v[c]   = PCout;
        if (c == 11) start = 1'b0;
      end
      chk("b2b busy never drops", 64'(busy_v), 64'(12'hFFF));
      chk("b2b done cycles",      64'(done_v), 64'(12'h820));
      chk("b2b T0 cycles",        64'(pc_v),   64'(12'h041));
      @(negedge clk);
      chk("b2b idle after", 64'(busy), 64'(0));
    end

    // clr during the second T4 cycle of MUL.
    begin
      bit late;
      late = 1'b0;
      @(negedge clk);
      ir    = 32'h79B80000;
      start = 1'b1;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        start = 1'b0;
        if (c == 4) begin
          chk("mul T4a alu", 64'(ALUControl), 64'(12'h200));
          chk("mul T4a zin", 64'(Zin), 64'(0));
        end
      end
      chk("mul T4b rout", 64'(Rout), 64'(16'h0080));
      clr = 1'b1;
      @(negedge clk);
      chk("clr mid-T4 outputs", all_out, 64'h0);
      clr = 1'b0;
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        if (LOin || HIin || (|Rin) || busy) late = 1'b1;
      end
      chk("clr mid-T4 no late strobes", 64'(late), 64'(0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
